seg7_scan: RTL

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It sits directly downstream of the clock divider: it samples the divider's square-wave output `scan_clk` (typically 1 kHz) in the `clkin` domain, steps through the enabled digits on each rising edge, and drives anode and segment lines. Data is frame-latched so a digit never shows a mix of old and new values.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/hex7seg_decode.sv | 13 +
 rtl/seg7_scan.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: blank pattern and hex-to-segment table.
// Segment order is {g,f,e,d,c,b,a}, active low (common-anode display).
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[hex];
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode display driver: steps through enabled digits on each
// scan_clk rising edge, with data/dp/mask frame-latched into shadow registers.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                s1, s2, s3;
    logic                tick;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_mask;
    logic                started;

    logic                has_above;
    logic [IW-1:0]       above_idx;
    logic                boundary;
    logic [4*DIGITS-1:0] ld_data;
    logic [DIGITS-1:0]   ld_dp;
    logic [DIGITS-1:0]   ld_mask;
    logic                low_found;
    logic [IW-1:0]       low_idx;
    logic [IW-1:0]       nxt_idx;
    logic [DIGITS-1:0]   an_nxt;
    logic [6:0]          seg_dec;

    // Boundary decision uses the current shadow mask; the digit then selected
    // comes from whichever mask (reloaded or held) is in force after this tick.
    always_comb begin
        tick      = s2 & ~s3;
        has_above = 1'b0;
        above_idx = idx;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!has_above && sh_mask[i] && (IW'(i) > idx)) begin
                has_above = 1'b1;
                above_idx = IW'(i);
            end
        end
        boundary = !started || !has_above;
        ld_data  = boundary ? data     : sh_data;
        ld_dp    = boundary ? dp_in    : sh_dp;
        ld_mask  = boundary ? digit_en : sh_mask;

        low_found = 1'b0;
        low_idx   = idx;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!low_found && ld_mask[i]) begin
                low_found = 1'b1;
                low_idx   = IW'(i);
            end
        end
        nxt_idx = boundary ? low_idx : above_idx;

        an_nxt          = '1;
        an_nxt[nxt_idx] = 1'b0;
    end

    hex7seg_decode u_dec (
        .hex (ld_data[{nxt_idx, 2'b00} +: 4]),
        .seg (seg_dec)
    );

    always_ff @(posedge clkin) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            idx         <= '0;
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_mask     <= '0;
            started     <= 1'b0;
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            s1          <= scan_clk;
            s2          <= s1;
            s3          <= s2;
            frame_start <= 1'b0;
            if (!en) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else if (tick) begin
                if (boundary) begin
                    sh_data     <= data;
                    sh_dp       <= dp_in;
                    sh_mask     <= digit_en;
                    started     <= 1'b1;
                    frame_start <= 1'b1;
                end
                idx <= nxt_idx;
                if (|ld_mask) begin
                    an  <= an_nxt;
                    seg <= seg_dec;
                    dp  <= ~ld_dp[nxt_idx];
                end else begin
                    an  <= '1;
                    seg <= SEG_BLANK;
                    dp  <= 1'b1;
                end
            end
        end
    end

endmodule
